result_selecter_stage: RTL and testbench
========================================

Name: result_selecter_stage

Overview:
- Pipelined output stage of the FPU, directly downstream of result_control_logic.
- Takes the four final field selects plus the raw normalized sign/exponent/fraction and assembles the 32-bit IEEE-754 single result.
- Registers the result behind a valid/ready handshake with a one-entry skid buffer, so back-pressure from the consumer never drops or duplicates a result.

Parameters:
- none (format fixed to binary32)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream result and selects valid
- in_ready  output  1  stage can accept this cycle
- sign_select  input  sign::sign_select  final sign source
- exponent_select  input  exponent::exponent_select  final exponent source
- fraction_msb_select  input  fraction_msb::fraction_msb_select  source of result bit 22
- fraction_lsbs_select  input  fraction_lsbs::fraction_lsbs_select  source of result bits 21:0
- result_sign  input  1  computed sign
- result_exponent  input  10  biased exponent; only bits 7:0 used
- result_fraction  input  25  normalized significand; bit 23 is hidden, 22 msb, 21:0 lsbs
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- result  output  32  assembled IEEE-754 word
- status_flags  output  4  {invalid_nan, infinity, zero, denormal_flush}; present only with STATUS_FLAGS_EN

Behaviour:
- Field mux, combinational on inputs:
  - sign: ZERO→0, ONE→1, RESULT→result_sign.
  - exponent: ZEROS→8'h00, ONES→8'hFF, RESULT→result_exponent[7:0].
  - fraction msb: ZERO→0, ONE→1, RESULT→result_fraction[22].
  - fraction lsbs: ZEROS→22'h0, RESULT→result_fraction[21:0].
  - Any unlisted encoding→0 for that field.
- Handshake:
  - Transfer on in_valid & in_ready in, and on out_valid & out_ready out.
  - Latency: 1 cycle from accepted input to out_valid.
  - in_ready is registered: in_ready = ~skid_full.
- Storage: main register (out_*) plus one skid register.
  - Input accepted, output empty or draining: the assembled word loads the main register.
  - Input accepted, main register held (out_valid & ~out_ready): the word loads the skid register; skid_full←1; in_ready drops next cycle.
  - Skid full and main register drains: the skid register moves to the main register the same cycle; skid_full←0.
  - Skid empty, main drains, no new input: out_valid←0.
  - Simultaneous accept and drain with skid empty: the new word replaces the main register; out_valid stays 1.
- Order is strictly FIFO. Results are never dropped or duplicated. No acceptance while skid_full.
- Reset (async assert, sync deassert handled externally):
  - out_valid=0, skid_full=0, in_ready=1, result=32'h0, status_flags=4'h0.
  - Reset mid-transfer discards both entries.
- result is held stable while out_valid & ~out_ready.

Optional Feature:
- Macro: STATUS_FLAGS_EN.
- Defined: status_flags is computed from the assembled word and registered alongside it, including through the skid register.
  - invalid_nan = exp==FF & frac!=0.
  - infinity = exp==FF & frac==0.
  - zero = exp==0 & frac==0.
  - denormal_flush = exponent_select==ZEROS & result_fraction!=0 & fraction selects both zero.
- Undefined: the status_flags port and its registers are absent.

Decomposition:
- Select enums stay in the existing sign, exponent, fraction_msb, fraction_lsbs packages.
- Add to a shared fpu_format package:
  - EXP_ONES=8'hFF, EXP_ZEROS=8'h00, FRAC_MSB_BIT=22, FRAC_LSBS_WIDTH=22
  - a result_word_t packed struct {sign, exponent[7:0], fraction[22:0]}
- One sub-module is natural: result_field_mux, the purely combinational assembly of result_word_t from the selects. The top level holds the skid/handshake logic.

Test Plan:
- All selects RESULT, sign 0, exponent 10'd127, fraction 25'h0C00000, out_ready=1 → one cycle later out_valid=1, result=32'h3FC00000.
- exponent ONES, msb ONE, lsbs ZEROS, sign RESULT=1 → result=32'hFFC00000; with STATUS_FLAGS_EN, invalid_nan=1.
- exponent ONES, msb ZERO, lsbs ZEROS, sign 0 → result=32'h7F800000; infinity=1.
- Three back-to-back inputs (A,B,C) with out_ready=0 → A in main, B in skid, in_ready=0 on cycle 3, C held upstream. Raise out_ready → A, B, C emerge in order, none lost.
- Continuous in_valid with out_ready toggling 1/0 every cycle for 20 words → output sequence equals input sequence, and result is stable whenever out_ready=0.
- Assert reset with skid_full=1 → out_valid=0, in_ready=1, result=0 immediately; the first post-reset word appears after exactly 1 cycle.

Source files
------------

// File: rtl/result_selecter_stage_pkg.sv
// Shared types for the FPU result output stage.
// result_selecter_stage_pkg : occupancy encoding of the output stage storage.
// sign / exponent / fraction_msb / fraction_lsbs : final field select enums.
// fpu_format : binary32 field constants and the assembled result word type.

package result_selecter_stage_pkg;
    // How many results the stage is holding: none, main register only,
    // or main register plus skid register.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } occupancy_t;
endpackage

package sign;
    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        ONE    = 2'd1,
        RESULT = 2'd2
    } sign_select;
endpackage

package exponent;
    typedef enum logic [1:0] {
        ZEROS  = 2'd0,
        ONES   = 2'd1,
        RESULT = 2'd2
    } exponent_select;
endpackage

package fraction_msb;
    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        ONE    = 2'd1,
        RESULT = 2'd2
    } fraction_msb_select;
endpackage

package fraction_lsbs;
    typedef enum logic [1:0] {
        ZEROS  = 2'd0,
        RESULT = 2'd1
    } fraction_lsbs_select;
endpackage

package fpu_format;
    localparam logic [7:0] EXP_ONES        = 8'hFF;
    localparam logic [7:0] EXP_ZEROS       = 8'h00;
    localparam int         FRAC_MSB_BIT    = 22;
    localparam int         FRAC_LSBS_WIDTH = 22;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } result_word_t;
endpackage

// File: rtl/result_field_mux.sv
// Purely combinational assembly of the binary32 result word from the four
// final field selects and the raw normalized sign/exponent/significand.
// Unlisted select encodings force their field to zero.

module result_field_mux
    import fpu_format::*;
(
    input  sign::sign_select                   sign_select,
    input  exponent::exponent_select           exponent_select,
    input  fraction_msb::fraction_msb_select   fraction_msb_select,
    input  fraction_lsbs::fraction_lsbs_select fraction_lsbs_select,
    input  logic                               result_sign,
    input  logic [9:0]                         result_exponent,
    input  logic [24:0]                        result_fraction,
    output result_word_t                       word
);

    // The exponent overflow bits and the hidden bit never reach the word.
    logic unused_bits;
    assign unused_bits = ^{result_exponent[9:8], result_fraction[24:23]};

    // Per-field source selection.
    always_comb begin
        word = '0;

        case (sign_select)
            sign::ONE:    word.sign = 1'b1;
            sign::RESULT: word.sign = result_sign;
            default:      word.sign = 1'b0;
        endcase

        case (exponent_select)
            exponent::ZEROS:  word.exponent = EXP_ZEROS;
            exponent::ONES:   word.exponent = EXP_ONES;
            exponent::RESULT: word.exponent = result_exponent[7:0];
            default:          word.exponent = 8'h00;
        endcase

        case (fraction_msb_select)
            fraction_msb::ONE:    word.fraction[FRAC_MSB_BIT] = 1'b1;
            fraction_msb::RESULT: word.fraction[FRAC_MSB_BIT] = result_fraction[FRAC_MSB_BIT];
            default:              word.fraction[FRAC_MSB_BIT] = 1'b0;
        endcase

        case (fraction_lsbs_select)
            fraction_lsbs::RESULT:
                word.fraction[FRAC_LSBS_WIDTH-1:0] = result_fraction[FRAC_LSBS_WIDTH-1:0];
            default:
                word.fraction[FRAC_LSBS_WIDTH-1:0] = '0;
        endcase
    end

endmodule

// File: rtl/result_selecter_stage.sv
// FPU output stage: assembles the binary32 result and registers it behind a
// valid/ready handshake with a one-entry skid buffer.
// Optional macro STATUS_FLAGS_EN adds the registered status_flags output
// {invalid_nan, infinity, zero, denormal_flush}.
//
// Handshake: a word moves whenever valid and ready are both high on a rising
// clock edge, on either side. in_ready comes straight from state (it is low
// only while the skid register is occupied), so it never depends
// combinationally on out_ready. Order is strictly FIFO; nothing is dropped
// or duplicated.

module result_selecter_stage
    import result_selecter_stage_pkg::*;
    import fpu_format::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  sign::sign_select                   sign_select,
    input  exponent::exponent_select           exponent_select,
    input  fraction_msb::fraction_msb_select   fraction_msb_select,
    input  fraction_lsbs::fraction_lsbs_select fraction_lsbs_select,
    input  logic                               result_sign,
    input  logic [9:0]                         result_exponent,
    input  logic [24:0]                        result_fraction,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        result
`ifdef STATUS_FLAGS_EN
    ,
    output logic [3:0]                         status_flags
`endif
);

    occupancy_t   occupancy;
    occupancy_t   occupancy_next;
    result_word_t word;
    result_word_t main_word;
    result_word_t skid_word;
    logic         accept;

    result_field_mux u_field_mux (
        .sign_select          (sign_select),
        .exponent_select      (exponent_select),
        .fraction_msb_select  (fraction_msb_select),
        .fraction_lsbs_select (fraction_lsbs_select),
        .result_sign          (result_sign),
        .result_exponent      (result_exponent),
        .result_fraction      (result_fraction),
        .word                 (word)
    );

    assign in_ready  = (occupancy != OCC_FULL);
    assign out_valid = (occupancy != OCC_EMPTY);
    assign accept    = in_valid & in_ready;
    assign result    = main_word;

`ifdef STATUS_FLAGS_EN
    logic [3:0] word_flags;
    logic [3:0] main_flags;
    logic [3:0] skid_flags;

    // Classify the assembled word; denormal_flush marks a nonzero significand
    // that the selects deliberately squashed to zero.
    always_comb begin
        word_flags    = 4'h0;
        word_flags[3] = (word.exponent == EXP_ONES)  && (word.fraction != '0);
        word_flags[2] = (word.exponent == EXP_ONES)  && (word.fraction == '0);
        word_flags[1] = (word.exponent == EXP_ZEROS) && (word.fraction == '0);
        word_flags[0] = (exponent_select == exponent::ZEROS)
                     && (result_fraction != '0)
                     && (fraction_msb_select == fraction_msb::ZERO)
                     && (fraction_lsbs_select == fraction_lsbs::ZEROS);
    end

    assign status_flags = main_flags;
`endif

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= OCC_EMPTY;
        end else begin
            occupancy <= occupancy_next;
        end
    end

    // Occupancy transitions: accept fills, out_ready drains.
    always_comb begin
        occupancy_next = occupancy;
        case (occupancy)
            OCC_EMPTY: begin
                if (accept) occupancy_next = OCC_MAIN;
            end
            OCC_MAIN: begin
                if (accept && !out_ready)      occupancy_next = OCC_FULL;
                else if (!accept && out_ready) occupancy_next = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (out_ready) occupancy_next = OCC_MAIN;
            end
            default: occupancy_next = OCC_EMPTY;
        endcase
    end

    // Data registers: the skid entry moves up first when it exists; otherwise
    // a new word goes to main if main is empty or draining, else to skid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_word <= '0;
            skid_word <= '0;
`ifdef STATUS_FLAGS_EN
            main_flags <= 4'h0;
            skid_flags <= 4'h0;
`endif
        end else if (occupancy == OCC_FULL) begin
            if (out_ready) begin
                main_word <= skid_word;
`ifdef STATUS_FLAGS_EN
                main_flags <= skid_flags;
`endif
            end
        end else if (accept) begin
            if (occupancy == OCC_EMPTY || out_ready) begin
                main_word <= word;
`ifdef STATUS_FLAGS_EN
                main_flags <= word_flags;
`endif
            end else begin
                skid_word <= word;
`ifdef STATUS_FLAGS_EN
                skid_flags <= word_flags;
`endif
            end
        end
    end

endmodule

// File: tb/tb_result_selecter_stage.sv
// Directed testbench for result_selecter_stage: field assembly vectors,
// skid back-pressure ordering, toggling out_ready, and reset with a full skid.

module tb_result_selecter_stage;

    logic                               clk;
    logic                               reset;
    logic                               in_valid;
    logic                               in_ready;
    sign::sign_select                   sign_select;
    exponent::exponent_select           exponent_select;
    fraction_msb::fraction_msb_select   fraction_msb_select;
    fraction_lsbs::fraction_lsbs_select fraction_lsbs_select;
    logic                               result_sign;
    logic [9:0]                         result_exponent;
    logic [24:0]                        result_fraction;
    logic                               out_valid;
    logic                               out_ready;
    logic [31:0]                        result;
`ifdef STATUS_FLAGS_EN
    logic [3:0]                         status_flags;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    result_selecter_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .sign_select          (sign_select),
        .exponent_select      (exponent_select),
        .fraction_msb_select  (fraction_msb_select),
        .fraction_lsbs_select (fraction_lsbs_select),
        .result_sign          (result_sign),
        .result_exponent      (result_exponent),
        .result_fraction      (result_fraction),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .result               (result)
`ifdef STATUS_FLAGS_EN
        ,
        .status_flags         (status_flags)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // Drive a word with all selects on RESULT.
    task automatic drive_raw(input logic s, input logic [9:0] e, input logic [24:0] f);
        sign_select          = sign::RESULT;
        exponent_select      = exponent::RESULT;
        fraction_msb_select  = fraction_msb::RESULT;
        fraction_lsbs_select = fraction_lsbs::RESULT;
        result_sign          = s;
        result_exponent      = e;
        result_fraction      = f;
    endtask

    // One word through an idle stage with out_ready high: visible one cycle
    // after acceptance, gone the cycle after.
    task automatic one_word(input string tag,
                            input sign::sign_select ss,
                            input exponent::exponent_select es,
                            input fraction_msb::fraction_msb_select ms,
                            input fraction_lsbs::fraction_lsbs_select ls,
                            input logic s, input logic [9:0] e, input logic [24:0] f,
                            input logic [31:0] want_word, input logic [3:0] want_flags);
        sign_select          = ss;
        exponent_select      = es;
        fraction_msb_select  = ms;
        fraction_lsbs_select = ls;
        result_sign          = s;
        result_exponent      = e;
        result_fraction      = f;
        in_valid             = 1'b1;
        out_ready            = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, result, want_word);
`ifdef STATUS_FLAGS_EN
        check({tag, "_flags"}, 32'(status_flags), 32'(want_flags));
`else
        if (want_flags === 4'bxxxx) $display("unused flag expectation");
`endif
        @(posedge clk); #1;
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0] word_a, word_b, word_c, held;
    logic        hold;
    int          sent, got, spurious;

    initial begin
        // Reset and idle inputs
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_raw(1'b0, 10'd0, 25'd0);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_result", result, 32'h0);
`ifdef STATUS_FLAGS_EN
        check("reset_flags", 32'(status_flags), 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Field assembly vectors
        one_word("normal", sign::RESULT, exponent::RESULT, fraction_msb::RESULT, fraction_lsbs::RESULT,
                 1'b0, 10'd127, 25'h0C00000, 32'h3FC00000, 4'b0000);
        one_word("qnan", sign::RESULT, exponent::ONES, fraction_msb::ONE, fraction_lsbs::ZEROS,
                 1'b1, 10'd5, 25'h0000123, 32'hFFC00000, 4'b1000);
        one_word("inf", sign::ZERO, exponent::ONES, fraction_msb::ZERO, fraction_lsbs::ZEROS,
                 1'b1, 10'd5, 25'h0000000, 32'h7F800000, 4'b0100);
        one_word("flush", sign::ZERO, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS,
                 1'b1, 10'd3, 25'h0400001, 32'h00000000, 4'b0011);
        one_word("hibits", sign::ONE, exponent::RESULT, fraction_msb::RESULT, fraction_lsbs::RESULT,
                 1'b0, 10'h181, 25'h1812345, 32'hC0812345, 4'b0000);
        one_word("unlisted", sign::sign_select'(2'd3), exponent::exponent_select'(2'd3),
                 fraction_msb::fraction_msb_select'(2'd3), fraction_lsbs::fraction_lsbs_select'(2'd3),
                 1'b1, 10'd127, 25'h07FFFFF, 32'h00000000, 4'b0010);

        // Back-pressure: A to main, B to skid, C held upstream
        word_a = {1'b0, 8'h11, 23'h000AAA};
        word_b = {1'b1, 8'h22, 23'h000BBB};
        word_c = {1'b0, 8'h33, 23'h400CCC};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_raw(word_a[31], {2'b00, word_a[30:23]}, {2'b00, word_a[22:0]});
        @(posedge clk); #1;
        check("bp_a_main", result, word_a);
        check("bp_ready_1", 32'(in_ready), 32'd1);
        drive_raw(word_b[31], {2'b00, word_b[30:23]}, {2'b00, word_b[22:0]});
        @(posedge clk); #1;
        check("bp_ready_skid", 32'(in_ready), 32'd0);
        check("bp_a_held", result, word_a);
        drive_raw(word_c[31], {2'b00, word_c[30:23]}, {2'b00, word_c[22:0]});
        @(posedge clk); #1;
        check("bp_c_blocked", 32'(in_ready), 32'd0);
        check("bp_a_still", result, word_a);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_b_out", result, word_b);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_c_out", result, word_c);
        check("bp_c_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        check("bp_empty", 32'(out_valid), 32'd0);

        // Continuous input, out_ready toggling every cycle
        sent = 0;
        got = 0;
        spurious = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            if (sent < 20) begin
                in_valid = 1'b1;
                drive_raw(sent[0], 10'(sent * 7 + 3), 25'(sent * 32'h13579 + 1));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = cyc[0];
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back({result_sign, result_exponent[7:0], result_fraction[22:0]});
                sent++;
            end
            hold = out_valid && !out_ready;
            held = result;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) spurious++;
                else check("toggle_word", result, exp_q.pop_front());
                got++;
            end
            @(posedge clk); #1;
            if (hold) check("toggle_hold", result, held);
        end
        in_valid = 1'b0;
        check("toggle_count", 32'(got), 32'd20);
        check("toggle_spurious", 32'(spurious), 32'd0);

        // Reset while the skid register is occupied
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_raw(1'b0, 10'h055, 25'h0111111);
        @(posedge clk); #1;
        drive_raw(1'b1, 10'h066, 25'h0222222);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_skid_full", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_ready", 32'(in_ready), 32'd1);
        check("rst_async_result", result, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_raw(1'b0, 10'd127, 25'h0C00000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_result", result, 32'h3FC00000);
        @(posedge clk); #1;
        check("post_rst_no_stale", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
